alu_control_sequencer: RTL and testbench
========================================

// Module: alu_control_sequencer
// PURPOSE
//  Next-generation ALU control: decodes ALUOp/function_field into an ALU operation code and
//  sequences multi-cycle MULT/DIV. Sits between main control and ALU/HI-LO unit; raises stall
//  to freeze the PC and pipeline while a multi-cycle op runs, then pulses hilo_we on completion.
// PARAMETERS
//  FUNCT_W        6   width of function_field
//  OP_W           4   width of ALU_Operation (NOP = all ones)
//  MULDIV_CYCLES  32  BUSY-state cycles for MULT/DIV, >=1; counter width $clog2(MULDIV_CYCLES+1)
// PORTS
//  clk             in   1        rising-edge clock; sole clock
//  rst             in   1        synchronous, active-high reset
//  instr_valid     in   1        decode inputs are valid this cycle
//  ALUOp           in   2        00 add, 01 sub, 10 R-type (use funct), 11 reserved
//  function_field  in   FUNCT_W  R-type funct field
//  divisor_zero    in   1        divisor==0 (present only with ALU_CTRL_DIVZERO_EN)
//  ALU_Operation   out  OP_W     ALU operation code (combinational decode, gated by state)
//  muldiv_start    out  1        1-cycle pulse launching the mult/div unit
//  muldiv_op       out  1        0 = MULT, 1 = DIV; held from start until DONE ends
//  stall           out  1        high in every BUSY cycle
//  hilo_we         out  1        1-cycle HI/LO write enable, in DONE
//  div_by_zero     out  1        1-cycle flag in DONE (only with ALU_CTRL_DIVZERO_EN)
// BEHAVIOUR
//  Decode: ALUOp 00->0000, 01->0001, 11->1111. ALUOp 10, funct: 100000->0000, 100001->0010,
//   100010->0110, 101010->0111, 100100->0011, 100101->0100, 011000 MULT->1000,
//   011010 DIV->1001, other->1111. Decode is combinational in IDLE and DONE.
//  States: IDLE, BUSY, DONE. Reset: state IDLE, counter 0, muldiv_op 0; outputs
//   muldiv_start/stall/hilo_we/div_by_zero 0, ALU_Operation 1111 while rst high.
//  Accept: in IDLE or DONE, instr_valid & decode in {MULT,DIV} -> muldiv_start=1 same cycle,
//   muldiv_op captured, counter loads MULDIV_CYCLES-1, next state BUSY.
//  Non-muldiv or instr_valid=0 in IDLE/DONE: next state IDLE, no start.
//  BUSY: stall=1, ALU_Operation forced 1111, inputs ignored; counter decrements each cycle;
//   counter==0 -> DONE. BUSY lasts exactly MULDIV_CYCLES cycles.
//  DONE: one cycle, stall=0, hilo_we=1, decode active. Back-to-back: muldiv accepted in DONE
//   goes straight to BUSY with hilo_we and muldiv_start both high that cycle.
//  Latency: start pulse to hilo_we = MULDIV_CYCLES+1 cycles.
//  rst mid-BUSY: next cycle IDLE, stall 0, no hilo_we, op discarded.
// CONFIGURATION
//  ALU_CTRL_DIVZERO_EN defined: divisor_zero/div_by_zero exist; DIV accepted with
//   divisor_zero=1 skips BUSY (no start pulse), next cycle DONE with hilo_we=0, div_by_zero=1.
//  Undefined: ports absent; DIV always takes full BUSY sequence.
// TESTING (MULDIV_CYCLES=4)
//  ALUOp=10 funct 100010/101010/100101/111111 -> 0110/0111/0100/1111, stall stays 0.
//  MULT valid at cycle 0 -> start@0, stall cycles 1-4, hilo_we@5, muldiv_op=0.
//  DIV accepted in DONE of a MULT -> hilo_we & start same cycle, BUSY 4 cycles, muldiv_op=1.
//  rst high at 2nd BUSY cycle -> IDLE next cycle, stall 0, no hilo_we, ALU_Operation 1111.
//  Inputs toggled during BUSY (ALUOp 00, funct MULT) -> ALU_Operation 1111, no new start.
//  DIVZERO_EN: DIV with divisor_zero=1 -> no start, next cycle div_by_zero=1, hilo_we=0.

Source files
------------

// File: rtl/alu_control_sequencer_if.sv
// Decode/sequencing bus between main control (master) and the ALU control sequencer (slave).
// Optional divide-by-zero signals exist only when ALU_CTRL_DIVZERO_EN is defined.
interface alu_control_sequencer_if #(
  parameter int unsigned FUNCT_W = 6,
  parameter int unsigned OP_W    = 4
);
  logic               instr_valid;
  logic [1:0]         ALUOp;
  logic [FUNCT_W-1:0] function_field;
`ifdef ALU_CTRL_DIVZERO_EN
  logic               divisor_zero;
  logic               div_by_zero;
`endif
  logic [OP_W-1:0]    ALU_Operation;
  logic               muldiv_start;
  logic               muldiv_op;
  logic               stall;
  logic               hilo_we;

  modport master (
`ifdef ALU_CTRL_DIVZERO_EN
    output divisor_zero,
    input  div_by_zero,
`endif
    output instr_valid,
    output ALUOp,
    output function_field,
    input  ALU_Operation,
    input  muldiv_start,
    input  muldiv_op,
    input  stall,
    input  hilo_we
  );

  modport slave (
`ifdef ALU_CTRL_DIVZERO_EN
    input  divisor_zero,
    output div_by_zero,
`endif
    input  instr_valid,
    input  ALUOp,
    input  function_field,
    output ALU_Operation,
    output muldiv_start,
    output muldiv_op,
    output stall,
    output hilo_we
  );
endinterface

// File: rtl/alu_control_sequencer.sv
// ALU operation decode plus IDLE/BUSY/DONE sequencing of multi-cycle MULT/DIV.
// Optional feature macro: ALU_CTRL_DIVZERO_EN (DIV by zero skips BUSY and flags div_by_zero).
module alu_control_sequencer #(
  parameter int unsigned FUNCT_W       = 6,
  parameter int unsigned OP_W          = 4,
  parameter int unsigned MULDIV_CYCLES = 32
) (
  input logic                    clk,
  input logic                    rst,
  alu_control_sequencer_if.slave bus
);
  localparam int unsigned CntW = $clog2(MULDIV_CYCLES + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(MULDIV_CYCLES - 1);

  localparam logic [OP_W-1:0] OpAdd  = OP_W'(4'b0000);
  localparam logic [OP_W-1:0] OpSub  = OP_W'(4'b0001);
  localparam logic [OP_W-1:0] OpAddu = OP_W'(4'b0010);
  localparam logic [OP_W-1:0] OpAnd  = OP_W'(4'b0011);
  localparam logic [OP_W-1:0] OpOr   = OP_W'(4'b0100);
  localparam logic [OP_W-1:0] OpSubR = OP_W'(4'b0110);
  localparam logic [OP_W-1:0] OpSlt  = OP_W'(4'b0111);
  localparam logic [OP_W-1:0] OpMult = OP_W'(4'b1000);
  localparam logic [OP_W-1:0] OpDiv  = OP_W'(4'b1001);
  localparam logic [OP_W-1:0] OpNop  = '1;

  localparam logic [FUNCT_W-1:0] FnAdd  = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] FnAddu = FUNCT_W'(6'b100001);
  localparam logic [FUNCT_W-1:0] FnSub  = FUNCT_W'(6'b100010);
  localparam logic [FUNCT_W-1:0] FnSlt  = FUNCT_W'(6'b101010);
  localparam logic [FUNCT_W-1:0] FnAnd  = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] FnOr   = FUNCT_W'(6'b100101);
  localparam logic [FUNCT_W-1:0] FnMult = FUNCT_W'(6'b011000);
  localparam logic [FUNCT_W-1:0] FnDiv  = FUNCT_W'(6'b011010);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            op_q;
  logic            dz_q;

  logic [OP_W-1:0] dec_op;
  logic            is_mul, is_div, accept, dz_accept;

  always_comb begin
    dec_op = OpNop;
    unique case (bus.ALUOp)
      2'b00: dec_op = OpAdd;
      2'b01: dec_op = OpSub;
      2'b10: begin
        case (bus.function_field)
          FnAdd:   dec_op = OpAdd;
          FnAddu:  dec_op = OpAddu;
          FnSub:   dec_op = OpSubR;
          FnSlt:   dec_op = OpSlt;
          FnAnd:   dec_op = OpAnd;
          FnOr:    dec_op = OpOr;
          FnMult:  dec_op = OpMult;
          FnDiv:   dec_op = OpDiv;
          default: dec_op = OpNop;
        endcase
      end
      default: dec_op = OpNop;
    endcase
  end

  assign is_mul = (dec_op == OpMult);
  assign is_div = (dec_op == OpDiv);
  assign accept = !rst && (state_q != StBusy) && bus.instr_valid && (is_mul || is_div);

`ifdef ALU_CTRL_DIVZERO_EN
  assign dz_accept = accept && is_div && bus.divisor_zero;
`else
  assign dz_accept = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StBusy: begin
          if (cnt_q == '0) state_q <= StDone;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: begin
          // IDLE and DONE accept alike, so a DONE can chain straight into the next op.
          dz_q <= 1'b0;
          if (accept) begin
            op_q <= is_div;
            if (dz_accept) begin
              state_q <= StDone;
              dz_q    <= 1'b1;
            end else begin
              state_q <= StBusy;
              cnt_q   <= CntLoad;
            end
          end else begin
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

  assign bus.ALU_Operation = (rst || state_q == StBusy) ? OpNop : dec_op;
  assign bus.muldiv_start  = accept && !dz_accept;
  assign bus.muldiv_op     = accept ? is_div : op_q;
  assign bus.stall         = !rst && (state_q == StBusy);
  assign bus.hilo_we       = !rst && (state_q == StDone) && !dz_q;
`ifdef ALU_CTRL_DIVZERO_EN
  assign bus.div_by_zero   = !rst && (state_q == StDone) && dz_q;
`endif
endmodule

// File: tb/tb_alu_control_sequencer.sv
// Scoreboard bench: stimulus pushes per-cycle expectations from a transaction-level model,
// a negedge monitor pops and compares against the DUT outputs.
module tb_alu_control_sequencer;
  localparam int unsigned Cyc = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_control_sequencer_if #(.FUNCT_W(6), .OP_W(4)) bus ();

  alu_control_sequencer #(
    .FUNCT_W      (6),
    .OP_W         (4),
    .MULDIV_CYCLES(Cyc)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [3:0] alu;
    bit         start;
    bit         op;
    bit         op_chk;
    bit         stall;
    bit         hilo;
    bit         dbz;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  // Model state: remaining stall cycles, whether a completion cycle is due, and its kind.
  int busy_left = 0;
  bit done_pend = 0;
  bit done_dz   = 0;
  bit cur_op    = 0;

  logic [5:0] funct_pool [10] = '{6'b100000, 6'b100001, 6'b100010, 6'b101010, 6'b100100,
                                  6'b100101, 6'b011000, 6'b011010, 6'b111111, 6'b000000};

  function automatic logic [3:0] ref_decode(input logic [1:0] aluop, input logic [5:0] fn);
    if (aluop == 2'b00) return 4'b0000;
    if (aluop == 2'b01) return 4'b0001;
    if (aluop == 2'b11) return 4'b1111;
    case (fn)
      6'b100000: return 4'b0000;
      6'b100001: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b101010: return 4'b0111;
      6'b100100: return 4'b0011;
      6'b100101: return 4'b0100;
      6'b011000: return 4'b1000;
      6'b011010: return 4'b1001;
      default:   return 4'b1111;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
  endtask

  task automatic drive(input bit r, input bit v, input logic [1:0] aluop, input logic [5:0] fn,
                       input bit dz);
    exp_t e;
    logic [3:0] code;
    rst                = r;
    bus.instr_valid    = v;
    bus.ALUOp          = aluop;
    bus.function_field = fn;
`ifdef ALU_CTRL_DIVZERO_EN
    bus.divisor_zero   = dz;
`endif
    e = '{alu: 4'hF, start: 0, op: 0, op_chk: 0, stall: 0, hilo: 0, dbz: 0};
    if (r) begin
      busy_left = 0;
      done_pend = 0;
      done_dz   = 0;
      cur_op    = 0;
    end else if (busy_left > 0) begin
      e.stall  = 1;
      e.op     = cur_op;
      e.op_chk = 1;
      busy_left--;
      if (busy_left == 0) done_pend = 1;
    end else begin
      e.hilo    = done_pend && !done_dz;
      e.dbz     = done_pend && done_dz;
      done_pend = 0;
      done_dz   = 0;
      code      = ref_decode(aluop, fn);
      e.alu     = code;
      if (v && (code == 4'b1000 || code == 4'b1001)) begin
        cur_op = (code == 4'b1001);
`ifdef ALU_CTRL_DIVZERO_EN
        if (cur_op && dz) begin
          done_pend = 1;
          done_dz   = 1;
        end else begin
          e.start   = 1;
          busy_left = Cyc;
        end
`else
        e.start   = 1;
        busy_left = Cyc;
`endif
      end
      e.op     = cur_op;
      e.op_chk = 1;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("alu_operation", int'(bus.ALU_Operation), int'(e.alu));
      check("muldiv_start", int'(bus.muldiv_start), int'(e.start));
      check("stall", int'(bus.stall), int'(e.stall));
      check("hilo_we", int'(bus.hilo_we), int'(e.hilo));
      if (e.op_chk) check("muldiv_op", int'(bus.muldiv_op), int'(e.op));
`ifdef ALU_CTRL_DIVZERO_EN
      check("div_by_zero", int'(bus.div_by_zero), int'(e.dbz));
`endif
    end
  end

  localparam logic [5:0] FMult = 6'b011000;
  localparam logic [5:0] FDiv  = 6'b011010;

  initial begin
    rst                = 1'b1;
    bus.instr_valid    = 1'b0;
    bus.ALUOp          = 2'b00;
    bus.function_field = '0;
`ifdef ALU_CTRL_DIVZERO_EN
    bus.divisor_zero   = 1'b0;
`endif
    @(posedge clk);
    #1;
    drive(1, 0, 2'b00, 6'd0, 0);
    drive(1, 1, 2'b10, FMult, 0);
    drive(0, 0, 2'b00, 6'd0, 0);
    // R-type decodes
    drive(0, 1, 2'b10, 6'b100010, 0);
    drive(0, 1, 2'b10, 6'b101010, 0);
    drive(0, 1, 2'b10, 6'b100101, 0);
    drive(0, 1, 2'b10, 6'b111111, 0);
    drive(0, 1, 2'b01, 6'b111111, 0);
    drive(0, 1, 2'b11, 6'b100000, 0);
    // MULT with inputs toggling during BUSY, then DIV chained from DONE
    drive(0, 1, 2'b10, FMult, 0);
    drive(0, 1, 2'b00, FMult, 0);
    drive(0, 1, 2'b10, FMult, 0);
    drive(0, 1, 2'b10, FDiv, 0);
    drive(0, 0, 2'b00, FMult, 0);
    drive(0, 1, 2'b10, FDiv, 0);
    for (int i = 0; i < Cyc; i++) drive(0, 0, 2'b10, FMult, 0);
    drive(0, 0, 2'b00, 6'd0, 0);
    // Reset on the second BUSY cycle
    drive(0, 1, 2'b10, FMult, 0);
    drive(0, 0, 2'b00, 6'd0, 0);
    drive(1, 0, 2'b00, 6'd0, 0);
    for (int i = 0; i < Cyc + 2; i++) drive(0, 0, 2'b00, 6'd0, 0);
`ifdef ALU_CTRL_DIVZERO_EN
    drive(0, 1, 2'b10, FDiv, 1);
    drive(0, 0, 2'b00, 6'd0, 0);
    drive(0, 0, 2'b00, 6'd0, 0);
`endif
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 70, 2'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0) ? 6'($urandom) : funct_pool[$urandom_range(0, 9)],
            $urandom_range(0, 1) == 1);
    end
    drive(0, 0, 2'b00, 6'd0, 0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
